// File: rtl/sccb_pkg.sv
// Shared constants and FSM state encoding for the SCCB write master.
package sccb_pkg;

  localparam int PHASES         = 3;
  localparam int BITS_PER_PHASE = 9;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_START_A   = 4'd1,
    ST_START_B   = 4'd2,
    ST_BIT_SETUP = 4'd3,
    ST_BIT_HIGH  = 4'd4,
    ST_BIT_HOLD  = 4'd5,
    ST_STOP_A    = 4'd6,
    ST_STOP_B    = 4'd7,
    ST_STOP_C    = 4'd8
  } state_e;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period strobe: one-cycle tick every Q clk cycles, realigned on restart.
module sccb_tick_gen #(
  parameter int Q = 62
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(Q) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart || cnt_q == '0) cnt_d = CW'(Q - 1);
  end

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sccb_master.sv
// SCCB 3-phase write master: start, ID/address/data bytes with a released
// ninth cell each, stop. All timing is counted in quarter-period ticks.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         CLK_FREQ    = 25000000,
  parameter int         SCCB_FREQ   = 100000,
  parameter logic [7:0] CAMERA_ADDR = 8'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic       ready,
  output logic       sioc,
  output logic       siod_o,
  output logic       siod_oe
);

  localparam int Q = CLK_FREQ / (4 * SCCB_FREQ);

  generate
    if (Q < 1) begin : g_bad_q
      $error("sccb_master: CLK_FREQ too low for SCCB_FREQ (quarter period < 1)");
    end
  endgenerate

  state_e      state_q, state_d;
  logic [23:0] sreg_q, sreg_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  phase_q, phase_d;
  logic        half_q, half_d;
  logic        tick, accept;

  assign ready  = (state_q == ST_IDLE);
  assign accept = start && ready;

  sccb_tick_gen #(.Q(Q)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    half_d  = half_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d = ST_START_A;
        sreg_d  = {CAMERA_ADDR, address, data};
        bit_d   = '0;
        phase_d = '0;
        half_d  = 1'b0;
      end
    end else if (tick) begin
      case (state_q)
        ST_START_A:   state_d = ST_START_B;
        ST_START_B:   state_d = ST_BIT_SETUP;
        ST_BIT_SETUP: state_d = ST_BIT_HIGH;
        // high phase spans two quarters; half_q marks the second one
        ST_BIT_HIGH: begin
          half_d = ~half_q;
          if (half_q) state_d = ST_BIT_HOLD;
        end
        ST_BIT_HOLD: begin
          if (bit_q == 4'(BITS_PER_PHASE - 1)) begin
            bit_d = '0;
            if (phase_q == 2'(PHASES - 1)) begin
              phase_d = '0;
              state_d = ST_STOP_A;
            end else begin
              phase_d = phase_q + 2'd1;
              state_d = ST_BIT_SETUP;
            end
          end else begin
            bit_d   = bit_q + 4'd1;
            sreg_d  = {sreg_q[22:0], 1'b0};
            state_d = ST_BIT_SETUP;
          end
        end
        ST_STOP_A: state_d = ST_STOP_B;
        ST_STOP_B: state_d = ST_STOP_C;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sioc    = 1'b1;
    siod_o  = 1'b1;
    siod_oe = 1'b1;
    case (state_q)
      ST_START_A: siod_o = 1'b0;
      ST_START_B: begin
        sioc   = 1'b0;
        siod_o = 1'b0;
      end
      ST_BIT_SETUP, ST_BIT_HOLD, ST_BIT_HIGH: begin
        sioc    = (state_q == ST_BIT_HIGH);
        siod_o  = sreg_q[23];
        siod_oe = (bit_q != 4'(BITS_PER_PHASE - 1));
      end
      ST_STOP_A: begin
        sioc   = 1'b0;
        siod_o = 1'b0;
      end
      ST_STOP_B: siod_o = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      phase_q <= '0;
      half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      half_q  <= half_d;
    end
  end

endmodule
